// File: rtl/axis_sched_pkg.sv
// Shared constants for the weighted round-robin AXI-Stream scheduler:
// FSM state encodings and the pointer value loaded on reset.
package axis_sched_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int unsigned PTR_RESET = 0;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search: returns the first set bit of i_eligible found
// when scanning upward from i_start and wrapping past the top index.
module rr_pick #(
    parameter int S_COUNT = 4,
    parameter int IW      = 2
) (
    input  logic [S_COUNT-1:0] i_eligible,
    input  logic [IW-1:0]      i_start,
    output logic               o_found,
    output logic [IW-1:0]      o_index
);

    logic [IW:0] w_pos;

    // Scan from the farthest offset down to offset 0 so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            w_pos   = {1'b0, i_start} + (IW+1)'(k);
            w_pos   = (w_pos >= (IW+1)'(S_COUNT)) ? (w_pos - (IW+1)'(S_COUNT)) : w_pos;
            o_found = i_eligible[w_pos[IW-1:0]] ? 1'b1 : o_found;
            o_index = i_eligible[w_pos[IW-1:0]] ? w_pos[IW-1:0] : o_index;
        end
    end

endmodule

// File: rtl/axis_wrr_sched.sv
// Weighted round-robin grant scheduler for an AXI-Stream mux: each granted
// input owns the mux for up to weight[i] whole packets before rotation.
module axis_wrr_sched
    import axis_sched_pkg::*;
#(
    parameter int S_COUNT      = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [S_COUNT-1:0]                request,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   weight,
    input  logic                              beat,
    input  logic                              beat_last,
    output logic [S_COUNT-1:0]                grant,
    output logic                              grant_valid,
    output logic [$clog2(S_COUNT)-1:0]        grant_encoded,
    output logic [WEIGHT_WIDTH-1:0]           credit
);

    localparam int IW = $clog2(S_COUNT);

    logic [0:0]              r_state;
    logic [S_COUNT-1:0]      r_grant;
    logic                    r_grant_valid;
    logic [IW-1:0]           r_enc;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic                    r_in_pkt;
    logic [IW-1:0]           r_ptr;

    logic [WEIGHT_WIDTH-1:0] w_weight [S_COUNT];
    logic [S_COUNT-1:0]      w_eligible;
    logic [IW-1:0]           w_ptr_next;
    logic [IW-1:0]           w_start;
    logic                    w_release;
    logic                    w_found;
    logic [IW-1:0]           w_index;
    logic [S_COUNT-1:0]      w_onehot;

    logic [0:0]              w_state_nx;
    logic [S_COUNT-1:0]      w_grant_nx;
    logic                    w_grant_valid_nx;
    logic [IW-1:0]           w_enc_nx;
    logic [WEIGHT_WIDTH-1:0] w_credit_nx;
    logic                    w_in_pkt_nx;
    logic [IW-1:0]           w_ptr_nx;

    // Unpack weights and mark inputs that request with a non-zero weight.
    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            w_weight[i]   = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            w_eligible[i] = request[i] & (w_weight[i] != '0);
        end
    end

    assign w_ptr_next = (r_enc == IW'(S_COUNT - 1)) ? '0 : (r_enc + IW'(1));
    assign w_start    = (r_state == ST_GRANT) ? w_ptr_next : r_ptr;
    assign w_onehot   = {{(S_COUNT-1){1'b0}}, 1'b1} << w_index;

    // A turn ends on the last packet of the credit, or when an idle owner stops requesting.
    assign w_release = (r_state == ST_GRANT) &&
                       ((beat && beat_last && (r_credit == WEIGHT_WIDTH'(1))) ||
                        (!r_in_pkt && !beat && !request[r_enc] && (r_credit != '0)));

    rr_pick #(
        .S_COUNT (S_COUNT),
        .IW      (IW)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_start    (w_start),
        .o_found    (w_found),
        .o_index    (w_index)
    );

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nx       = r_state;
        w_grant_nx       = r_grant;
        w_grant_valid_nx = r_grant_valid;
        w_enc_nx         = r_enc;
        w_credit_nx      = r_credit;
        w_in_pkt_nx      = r_in_pkt;
        w_ptr_nx         = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx       = ST_GRANT;
                    w_grant_nx       = w_onehot;
                    w_grant_valid_nx = 1'b1;
                    w_enc_nx         = w_index;
                    w_credit_nx      = w_weight[w_index];
                    w_in_pkt_nx      = 1'b0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nx    = w_ptr_next;
                    w_in_pkt_nx = 1'b0;
                    if (w_found) begin
                        w_state_nx       = ST_GRANT;
                        w_grant_nx       = w_onehot;
                        w_grant_valid_nx = 1'b1;
                        w_enc_nx         = w_index;
                        w_credit_nx      = w_weight[w_index];
                    end else begin
                        w_state_nx       = ST_IDLE;
                        w_grant_nx       = '0;
                        w_grant_valid_nx = 1'b0;
                        w_enc_nx         = '0;
                        w_credit_nx      = '0;
                    end
                end else if (beat) begin
                    if (beat_last) begin
                        w_in_pkt_nx = 1'b0;
                        w_credit_nx = r_credit - WEIGHT_WIDTH'(1);
                    end else begin
                        w_in_pkt_nx = 1'b1;
                    end
                end else begin
                    w_in_pkt_nx = r_in_pkt;
                end
            end
            default: begin
                w_state_nx       = ST_IDLE;
                w_grant_nx       = '0;
                w_grant_valid_nx = 1'b0;
                w_enc_nx         = '0;
                w_credit_nx      = '0;
                w_in_pkt_nx      = 1'b0;
                w_ptr_nx         = IW'(PTR_RESET);
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_enc         <= '0;
            r_credit      <= '0;
            r_in_pkt      <= 1'b0;
            r_ptr         <= IW'(PTR_RESET);
        end else begin
            r_state       <= w_state_nx;
            r_grant       <= w_grant_nx;
            r_grant_valid <= w_grant_valid_nx;
            r_enc         <= w_enc_nx;
            r_credit      <= w_credit_nx;
            r_in_pkt      <= w_in_pkt_nx;
            r_ptr         <= w_ptr_nx;
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_enc;
    assign credit        = r_credit;

endmodule

// File: doc/axis_wrr_sched.md
AXIS_WRR_SCHED -- requirements
Module: axis_wrr_sched

Interface
REQ-001 The block SHALL have parameter S_COUNT, default 4, meaning number of requesting AXI-Stream inputs (2..16).
REQ-002 The block SHALL have parameter WEIGHT_WIDTH, default 4, meaning width of each per-input packet weight.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, sole clock; all state on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port request, input, S_COUNT, per-input tvalid.
REQ-007 Port weight, input, S_COUNT*WEIGHT_WIDTH, packets per turn, input i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 = input disabled.
REQ-008 Port beat, input, 1, one beat of the granted input transferred this cycle (tvalid&tready after mux).
REQ-009 Port beat_last, input, 1, tlast of that beat; ignored when beat=0.
REQ-010 Port grant, output, S_COUNT, one-hot grant, registered.
REQ-011 Port grant_valid, output, 1, grant is meaningful, registered.
REQ-012 Port grant_encoded, output, $clog2(S_COUNT), binary index of grant, registered.
REQ-013 Port credit, output, WEIGHT_WIDTH, packets remaining in current turn, registered.

Function
REQ-014 States: IDLE (no grant) and GRANT (one input owns the mux).
REQ-015 IDLE: eligible = request & (weight!=0); search starts at pointer ptr and wraps upward; first eligible wins.
REQ-016 IDLE with eligible!=0 SHALL go to GRANT on the next edge: grant=winner, grant_valid=1, credit=weight[winner] sampled on that edge; latency request->grant_valid exactly 1 cycle.
REQ-017 GRANT: beat&!beat_last SHALL set in_pkt; beat&beat_last SHALL clear in_pkt and decrement credit by 1.
REQ-018 Release conditions in GRANT: (a) beat&beat_last with credit==1; (b) !in_pkt and !beat and !request[grant_encoded] and credit>0.
REQ-019 Release SHALL never occur while in_pkt=1, regardless of request or weight changes.
REQ-020 On release, ptr SHALL become (grant_encoded+1) mod S_COUNT and the arbitration of REQ-015 SHALL be evaluated in the release cycle with that new pointer.
REQ-021 If the release-cycle arbitration finds a winner, grant SHALL switch to it on the next edge with no idle cycle; else go to IDLE with grant=0, grant_valid=0, credit=0.
REQ-022 A sole eligible input whose credit is exhausted SHALL be re-granted immediately with fresh credit.
REQ-023 Weight changes SHALL take effect only at the next grant; weight of an active grant dropping to 0 SHALL NOT abort it.
REQ-024 beat while grant_valid=0 SHALL be ignored (no state change).
REQ-025 grant SHALL always equal 1<<grant_encoded when grant_valid=1 and 0 otherwise.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, grant=0, grant_valid=0, grant_encoded=0, credit=0, in_pkt=0, ptr=0.
REQ-027 Reset asserted mid-packet SHALL drop the grant immediately; first grant after release follows REQ-016 from ptr=0.

Structure
REQ-028 State encodings and the reset pointer value SHALL live in shared package axis_sched_pkg.
REQ-029 The rotating first-one search SHALL be sub-module rr_pick (inputs: eligible vector, start pointer; outputs: found, index), purely combinational.

Verification
REQ-030 S_COUNT=4, weights all 1, request=4'b1111, each packet 2 beats -> grants 0,1,2,3,0 with no idle cycle between packets.
REQ-031 Weights {3,1,1,1} (input0=3), request=4'b0011, 1-beat packets -> input0 for 3 packets (credit 3,2,1), then input1 for 1, then input0.
REQ-032 Input2 granted, weight 2, request[2] drops after first packet, request=4'b1000 -> release next cycle with credit=1, grant_encoded=3.
REQ-033 weight[1]=0, request=4'b0010 -> grant_valid stays 0 indefinitely.
REQ-034 In-packet (in_pkt=1), request of granted input deasserts for 5 cycles -> grant held; after last beat, release per REQ-018(a) or (b).
REQ-035 rst_n pulsed low mid-packet on input3 -> grant/grant_valid 0 same cycle; after release with request=4'b1001, first grant is input0.
